bird_position: RTL and testbench
================================

Name: bird_position

Overview:
- Owns the bird's vertical position and produces the `gravity`, `top` and `bottom` signals that the out-of-bounds checker consumes.
- Each flap (rising edge of `key`) moves the bird up one row.
- Each periodic gravity tick moves the bird down one row.
- The position saturates at the playfield edges.
- The block freezes when the checker reports a hit.
- It sits between the flap-button synchronizer and the display/collision logic.

Parameters:
- ROWS, 16, number of playfield rows; row 0 is the top, row ROWS-1 is the bottom; ROWS >= 2.
- FALL_PERIOD, 4, clock cycles between gravity ticks; FALL_PERIOD >= 2.
- START_ROW, 7, row loaded on reset; 0 <= START_ROW <= ROWS-1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- key  input  1  flap button level, already synchronized to clk.
- hit  input  1  out-of-bounds/collision report; freezes the bird.
- row  output  $clog2(ROWS)  current bird row, binary, registered.
- row_onehot  output  ROWS  one-hot decode of `row` (bit i set when row == i).
- gravity  output  1  one-cycle gravity tick.
- top  output  1  1 when row == 0.
- bottom  output  1  1 when row == ROWS-1.
- alive  output  1  1 in state FLY.

Behaviour:
- One clock; reset is synchronous and active-high, and all registers update on posedge clk.
- Reset has priority over every other input, including mid-flight and in state DEAD. On reset:
  - state = IDLE, row = START_ROW, fall counter = 0, key_q = 0.
  - Therefore gravity = 0, alive = 0.
  - top and bottom follow row: both 0 for the default START_ROW.
- Flap detect: `flap = key & ~key_q`, where key_q is `key` registered.
  - Holding `key` high produces exactly one flap.
  - A new flap requires `key` low for at least one cycle first.
- States:
  - IDLE: counter held at 0, gravity = 0, row held. A flap sets state = FLY and row = row-1 (saturating at 0); the counter stays at 0. `hit` is ignored in IDLE.
  - FLY: the counter increments each cycle.
    - `gravity = (state == FLY) && (cnt == FALL_PERIOD-1)`. This is combinational, so it is high in the same cycle as the current `top`/`bottom`.
    - On a gravity cycle the counter wraps to 0.
    - A flap also clears the counter to 0.
  - DEAD: entered from FLY on the clock edge where `hit = 1`. `row` is frozen, the counter is held, gravity = 0, flaps are ignored. Only reset leaves DEAD.
- Row update in FLY, by priority:
  1. hit: no move.
  2. flap: row-1, saturating at 0.
  3. gravity: row+1, saturating at ROWS-1.
  4. Otherwise: hold.
- Simultaneous flap and gravity: the gravity pulse is still asserted for that cycle, the flap wins (row-1), and the counter restarts at 0.
- Edge saturation: the row never wraps.
  - A flap at row 0 leaves row = 0 with top = 1. The downstream checker flags this as `top & key & ~gravity`.
  - Gravity at row ROWS-1 leaves row = ROWS-1 with bottom = 1. The checker flags this as `bottom & ~key & gravity`.
- `hit` and flap in the same cycle: hit wins; no move, state = DEAD.
- top, bottom, row_onehot and alive are combinational decodes of registered state and row; there are no glitch requirements beyond synchronous use.
- Latency:
  - row changes on the first clock edge after the flap/gravity cycle.
  - gravity recurs every FALL_PERIOD cycles while in FLY with no flaps.

Test Plan (ROWS=16, FALL_PERIOD=4, START_ROW=7):
1. Reset 2 cycles, then idle 20 cycles with key=0 -> row=7, row_onehot=16'h0080, gravity never 1, alive=0, top=bottom=0.
2. key 0->1 held 10 cycles -> one cycle later row=6 and alive=1. Then gravity pulses every 4th cycle: row 7, 8, 9 at 4-cycle spacing. Holding key causes no further up-moves.
3. No flaps until the bird falls to row 15 -> bottom=1. Subsequent gravity pulses keep row=15; gravity and bottom are both 1 in the same cycle.
4. Key pulses (1 high, 1 low) repeated 20 times from row 6 -> row reaches 0, top=1. Further flaps keep row=0 and never show 15.
5. Key rise aligned with the cycle where cnt=3 -> gravity=1 that cycle, row goes from r to r-1 (not r+1), and the next gravity pulse arrives 4 cycles later.
6. In FLY at row 5, assert hit for 1 cycle -> alive=0, row stays 5, gravity stays 0 and key pulses are ignored for 20 cycles. Then reset=1 for one cycle -> row=7, state IDLE. Also: reset asserted mid-fall -> row=7 on the next edge.

Source files
------------

// File: rtl/bird_position.sv
// rtl/bird_position.sv - bird vertical position: flap moves up, gravity tick moves down, saturating rows.
// Freezes in DEAD after a hit until reset; top/bottom/gravity feed the out-of-bounds checker.
module bird_position #(
  parameter int ROWS        = 16,
  parameter int FALL_PERIOD = 4,
  parameter int START_ROW   = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    key,
  input  logic                    hit,
  output logic [$clog2(ROWS)-1:0] row,
  output logic [ROWS-1:0]         row_onehot,
  output logic                    gravity,
  output logic                    top,
  output logic                    bottom,
  output logic                    alive
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(FALL_PERIOD);
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
  localparam logic [RW-1:0] FIRST_ROW = RW'(START_ROW);
  localparam logic [CW-1:0] CNT_LAST  = CW'(FALL_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FLY  = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [RW-1:0] r_row;
  logic [RW-1:0] w_row_next;
  logic [RW-1:0] w_row_up;
  logic [RW-1:0] w_row_down;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_key_q;
  logic          w_flap;

  assign w_flap     = key & ~r_key_q;
  assign w_row_up   = (r_row == '0) ? r_row : r_row - 1'b1;
  assign w_row_down = (r_row == LAST_ROW) ? r_row : r_row + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_flap) w_state_next = S_FLY;
      S_FLY:   if (hit)    w_state_next = S_DEAD;
      S_DEAD:  w_state_next = S_DEAD;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Hit outranks flap, flap outranks gravity; a flap on a gravity cycle still restarts the period.
  always_comb begin
    w_row_next = r_row;
    w_cnt_next = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (w_flap) w_row_next = w_row_up;
      end
      S_FLY: begin
        if (!hit) begin
          if (w_flap) begin
            w_row_next = w_row_up;
            w_cnt_next = '0;
          end else if (gravity) begin
            w_row_next = w_row_down;
            w_cnt_next = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_row_next = r_row;
        w_cnt_next = r_cnt;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row   <= FIRST_ROW;
      r_cnt   <= '0;
      r_key_q <= 1'b0;
    end else begin
      r_row   <= w_row_next;
      r_cnt   <= w_cnt_next;
      r_key_q <= key;
    end
  end

  always_comb begin
    gravity = (r_state == S_FLY) && (r_cnt == CNT_LAST);
    alive   = (r_state == S_FLY);
    top     = (r_row == '0);
    bottom  = (r_row == LAST_ROW);
    for (int i = 0; i < ROWS; i++) begin
      row_onehot[i] = (r_row == RW'(i));
    end
  end

  assign row = r_row;

endmodule

// File: tb/tb_bird_position.sv
// tb/tb_bird_position.sv - scoreboard bench for bird_position against a cycle-level game model.
module tb_bird_position;

  localparam int ROWS  = 16;
  localparam int P     = 4;
  localparam int START = 7;

  logic            clk = 1'b0;
  logic            reset;
  logic            key;
  logic            hit;
  logic [3:0]      row;
  logic [ROWS-1:0] row_onehot;
  logic            gravity;
  logic            top;
  logic            bottom;
  logic            alive;

  bird_position #(.ROWS(ROWS), .FALL_PERIOD(P), .START_ROW(START)) dut (
    .clk(clk), .reset(reset), .key(key), .hit(hit),
    .row(row), .row_onehot(row_onehot), .gravity(gravity),
    .top(top), .bottom(bottom), .alive(alive)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]      row;
    logic [ROWS-1:0] oh;
    logic            g;
    logic            a;
    logic            t;
    logic            b;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Model: position, whether flying/dead, and cycles elapsed since flight start or last flap.
  int m_row;
  int m_since;
  bit m_fly;
  bit m_dead;
  bit m_kprev;

  function automatic bit model_grav();
    return m_fly && ((m_since % P) == P - 1);
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.row = 4'(m_row);
    e.oh  = '0;
    e.oh[m_row] = 1'b1;
    e.g   = model_grav();
    e.a   = m_fly;
    e.t   = (m_row == 0);
    e.b   = (m_row == ROWS - 1);
    return e;
  endfunction

  task automatic model_reset();
    m_row = START; m_since = 0; m_fly = 0; m_dead = 0; m_kprev = 0;
  endtask

  task automatic model_step(input bit r, input bit k, input bit h);
    bit g;
    bit flap;
    g    = model_grav();
    flap = k && !m_kprev;
    if (r) begin
      model_reset();
      return;
    end
    m_kprev = k;
    if (m_dead) return;
    if (!m_fly) begin
      if (flap) begin
        m_fly = 1; m_since = 0;
        if (m_row > 0) m_row--;
      end
    end else if (h) begin
      m_fly = 0; m_dead = 1;
    end else if (flap) begin
      m_since = 0;
      if (m_row > 0) m_row--;
    end else begin
      if (g && m_row < ROWS - 1) m_row++;
      m_since++;
    end
  endtask

  task automatic cyc(input bit r, input bit k, input bit h);
    q.push_back(model_out());
    reset = r; key = k; hit = h;
    model_step(r, k, h);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_vec++;
      chk("row",        32'(row),        32'(e.row));
      chk("row_onehot", 32'(row_onehot), 32'(e.oh));
      chk("gravity",    32'(gravity),    32'(e.g));
      chk("alive",      32'(alive),      32'(e.a));
      chk("top",        32'(top),        32'(e.t));
      chk("bottom",     32'(bottom),     32'(e.b));
    end
  end

  initial begin
    bit k;
    reset = 1'b1; key = 1'b0; hit = 1'b0;
    @(posedge clk);
    #1;
    model_reset();

    // Reset then idle
    repeat (2) cyc(1, 0, 0);
    repeat (20) cyc(0, 0, 0);
    // Held key: one flap only, then gravity every P cycles
    repeat (10) cyc(0, 1, 0);
    // Fall to the bottom and sit there under further gravity
    repeat (60) cyc(0, 0, 0);
    // Repeated flaps climb to the top and saturate
    repeat (25) begin
      cyc(0, 1, 0);
      cyc(0, 0, 0);
    end
    // Flap coinciding with a gravity tick
    repeat (8) cyc(0, 0, 0);
    cyc(0, 1, 0);
    repeat (3) cyc(0, 0, 0);
    cyc(0, 1, 0);
    repeat (10) cyc(0, 0, 0);
    // Hit freezes, flaps ignored, then reset recovers
    cyc(0, 0, 1);
    repeat (10) begin
      cyc(0, 1, 0);
      cyc(0, 0, 0);
    end
    cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
    // Reset mid-fall
    cyc(0, 1, 0);
    repeat (9) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
    // Hit in IDLE has no effect
    cyc(0, 0, 1);
    cyc(0, 1, 0);
    repeat (6) cyc(0, 0, 0);

    k = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) k = !k;
      cyc(($urandom_range(0, 149) == 0), k, ($urandom_range(0, 59) == 0));
    end

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
